// File: rtl/rv32im_wb_arbiter_if.sv
// Write-back bus between the result producers (ALU, MUL/DIV) and the register-file write port.
// The arbiter sits on the slave side; the producers and regfile observers sit on the master side.
interface rv32im_wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [AW-1:0]         alu_rd_i;
  logic [XLEN-1:0]       alu_val_i;
  logic                  md_valid_i;
  logic                  md_ready_o;
  logic [AW-1:0]         md_rd_i;
  logic [XLEN-1:0]       md_val_i;
  logic                  we_o;
  logic [AW-1:0]         rd_addr_o;
  logic [XLEN-1:0]       val_rd_o;
  logic [(1<<AW)-1:0]    pending_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_val_i, md_valid_i, md_rd_i, md_val_i,
    output alu_ready_o, md_ready_o, we_o, rd_addr_o, val_rd_o, pending_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_val_i, md_valid_i, md_rd_i, md_val_i,
    input  alu_ready_o, md_ready_o, we_o, rd_addr_o, val_rd_o, pending_o
  );
endinterface

// File: rtl/rv32im_wb_arbiter.sv
// Merges ALU and buffered MUL/DIV results onto one registered regfile write port,
// bounding ALU priority so queued MUL/DIV results cannot starve, and reports pending rds.
module rv32im_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned MD_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rv32im_wb_arbiter_if.slave  wb
);
  localparam int unsigned PW   = $clog2(MD_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
  localparam int unsigned NREG = 1 << AW;

  logic [AW-1:0]   fifo_rd  [MD_DEPTH];
  logic [XLEN-1:0] fifo_val [MD_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic            we_q;
  logic [AW-1:0]   rd_addr_q;
  logic [XLEN-1:0] val_q;
  logic            fifo_empty, fifo_full, force_md, push, pop, alu_grant;
  logic [PW-1:0]   off;
  logic [NREG-1:0] pending;

  // Grant depends only on registered state, so ready never depends on valid.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(MD_DEPTH));
    force_md   = !fifo_empty && (starve_q == SW'(STARVE_MAX));
    push       = wb.md_valid_i && !fifo_full;
    pop        = !fifo_empty && (force_md || !wb.alu_valid_i);
    alu_grant  = wb.alu_valid_i && !pop;
    starve_d   = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_grant && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign wb.alu_ready_o = !force_md;
  assign wb.md_ready_o  = !fifo_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      val_q     <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q  <= count_q + CW'(push) - CW'(pop);
      starve_q <= starve_d;
      if (pop) begin
        we_q      <= (fifo_rd[head_q] != '0);
        rd_addr_q <= fifo_rd[head_q];
        val_q     <= fifo_val[head_q];
      end else if (alu_grant) begin
        we_q      <= (wb.alu_rd_i != '0);
        rd_addr_q <= wb.alu_rd_i;
        val_q     <= wb.alu_val_i;
      end else begin
        we_q      <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_rd[tail_q]  <= wb.md_rd_i;
      fifo_val[tail_q] <= wb.md_val_i;
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    pending = '0;
    off     = '0;
    for (int unsigned i = 0; i < MD_DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ({1'b0, off} < count_q) pending[fifo_rd[i]] = 1'b1;
    end
    if (we_q) pending[rd_addr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign wb.we_o      = we_q;
  assign wb.rd_addr_o = rd_addr_q;
  assign wb.val_rd_o  = val_q;
  assign wb.pending_o = pending;
endmodule
